// File: rtl/sram_bw_port_arbiter.sv
// sram_bw_port_arbiter: round-robin two-port front end for a single-port bit-write SRAM macro,
// with zero-fill after reset/flush and held read data.
module sram_bw_port_arbiter #(
    parameter int Bits       = 128,
    parameter int Word_Depth = 64,
    parameter int Add_Width  = 6
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 flush,
    output logic                 init_done,
    input  logic                 s0_req_valid,
    output logic                 s0_req_ready,
    input  logic                 s0_req_write,
    input  logic [Add_Width-1:0] s0_req_addr,
    input  logic [Bits-1:0]      s0_req_wdata,
    input  logic [Bits-1:0]      s0_req_wmask,
    output logic                 s0_resp_valid,
    output logic [Bits-1:0]      s0_resp_rdata,
    input  logic                 s1_req_valid,
    output logic                 s1_req_ready,
    input  logic                 s1_req_write,
    input  logic [Add_Width-1:0] s1_req_addr,
    input  logic [Bits-1:0]      s1_req_wdata,
    input  logic [Bits-1:0]      s1_req_wmask,
    output logic                 s1_resp_valid,
    output logic [Bits-1:0]      s1_resp_rdata,
    output logic                 sram_CEN,
    output logic                 sram_WEN,
    output logic [Bits-1:0]      sram_BWEN,
    output logic [Add_Width-1:0] sram_A,
    output logic [Bits-1:0]      sram_D,
    input  logic [Bits-1:0]      sram_Q
);
    typedef enum logic {INIT, RUN} state_t;
    localparam logic [Add_Width-1:0] LAST = Add_Width'(Word_Depth - 1);

    state_t               state_q, state_d;
    logic [Add_Width-1:0] cnt_q, cnt_d;
    logic                 rr_q, rr_d;
    logic                 init_done_q, init_done_d;
    logic [1:0]           resp_valid_q, resp_valid_d;
    logic [Bits-1:0]      hold_q [2];
    logic [Bits-1:0]      hold_d [2];
    logic [1:0]           v, wr, grant;
    logic [Add_Width-1:0] ad [2];
    logic [Bits-1:0]      wd [2];
    logic [Bits-1:0]      wm [2];
    logic                 run, gi;

    assign v     = {s1_req_valid, s0_req_valid};
    assign wr    = {s1_req_write, s0_req_write};
    assign ad[0] = s0_req_addr;
    assign ad[1] = s1_req_addr;
    assign wd[0] = s0_req_wdata;
    assign wd[1] = s1_req_wdata;
    assign wm[0] = s0_req_wmask;
    assign wm[1] = s1_req_wmask;

    // rr_q=0 favours s0 on a tie; no grant while flushing or in reset
    always_comb begin
        run          = state_q == RUN && !flush && !reset;
        grant[0]     = run && v[0] && (!v[1] || !rr_q);
        grant[1]     = run && v[1] && (!v[0] || rr_q);
        gi           = grant[1];
        rr_d         = grant[0] ? 1'b1 : grant[1] ? 1'b0 : rr_q;
        resp_valid_d = grant & ~wr;
        hold_d[0]    = resp_valid_q[0] ? sram_Q : hold_q[0];
        hold_d[1]    = resp_valid_q[1] ? sram_Q : hold_q[1];
        state_d      = state_q;
        cnt_d        = cnt_q;
        init_done_d  = init_done_q;
        sram_CEN     = 1'b1;
        sram_WEN     = 1'b1;
        sram_BWEN    = '1;
        sram_A       = '0;
        sram_D       = '0;
        if (state_q == INIT) begin
            sram_CEN  = 1'b0;
            sram_WEN  = 1'b0;
            sram_BWEN = '0;
            sram_A    = cnt_q;
            cnt_d     = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
                state_d     = RUN;
                init_done_d = 1'b1;
            end
        end else begin
            if (flush) begin
                state_d     = INIT;
                cnt_d       = '0;
                init_done_d = 1'b0;
            end
            if (|grant) begin
                sram_CEN  = 1'b0;
                sram_WEN  = ~wr[gi];
                sram_BWEN = wr[gi] ? ~wm[gi] : '1;
                sram_A    = ad[gi];
                sram_D    = wr[gi] ? wd[gi] : '0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= INIT;
            cnt_q        <= '0;
            rr_q         <= 1'b0;
            init_done_q  <= 1'b0;
            resp_valid_q <= '0;
            hold_q[0]    <= '0;
            hold_q[1]    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rr_q         <= rr_d;
            init_done_q  <= init_done_d;
            resp_valid_q <= resp_valid_d;
            hold_q[0]    <= hold_d[0];
            hold_q[1]    <= hold_d[1];
        end
    end

    assign init_done     = init_done_q;
    assign s0_req_ready  = grant[0];
    assign s1_req_ready  = grant[1];
    assign s0_resp_valid = resp_valid_q[0];
    assign s1_resp_valid = resp_valid_q[1];
    assign s0_resp_rdata = resp_valid_q[0] ? sram_Q : hold_q[0];
    assign s1_resp_rdata = resp_valid_q[1] ? sram_Q : hold_q[1];
endmodule

// File: tb/tb_sram_bw_port_arbiter.sv
// tb_sram_bw_port_arbiter: scoreboard bench with a behavioural bit-write SRAM macro.
module tb_sram_bw_port_arbiter;
    localparam int B = 128, D = 64, AW = 6;

    logic clock = 1'b0, reset = 1'b1, flush = 1'b0, init_done, scramble = 1'b0;
    logic s0_req_valid = 1'b0, s0_req_ready, s0_req_write = 1'b0, s0_resp_valid;
    logic s1_req_valid = 1'b0, s1_req_ready, s1_req_write = 1'b0, s1_resp_valid;
    logic [AW-1:0] s0_req_addr = '0, s1_req_addr = '0, sram_A;
    logic [B-1:0] s0_req_wdata = '0, s0_req_wmask = '0, s0_resp_rdata;
    logic [B-1:0] s1_req_wdata = '0, s1_req_wmask = '0, s1_resp_rdata;
    logic sram_CEN, sram_WEN;
    logic [B-1:0] sram_BWEN, sram_D, sram_Q;
    logic [B-1:0] smem [D];
    logic [B-1:0] ref_mem [D];
    logic [B-1:0] q0 [$];
    logic [B-1:0] q1 [$];
    int checks = 0, errors = 0;

    sram_bw_port_arbiter #(.Bits(B), .Word_Depth(D), .Add_Width(AW)) dut (
        .clock(clock), .reset(reset), .flush(flush), .init_done(init_done),
        .s0_req_valid(s0_req_valid), .s0_req_ready(s0_req_ready), .s0_req_write(s0_req_write),
        .s0_req_addr(s0_req_addr), .s0_req_wdata(s0_req_wdata), .s0_req_wmask(s0_req_wmask),
        .s0_resp_valid(s0_resp_valid), .s0_resp_rdata(s0_resp_rdata),
        .s1_req_valid(s1_req_valid), .s1_req_ready(s1_req_ready), .s1_req_write(s1_req_write),
        .s1_req_addr(s1_req_addr), .s1_req_wdata(s1_req_wdata), .s1_req_wmask(s1_req_wmask),
        .s1_resp_valid(s1_resp_valid), .s1_resp_rdata(s1_resp_rdata),
        .sram_CEN(sram_CEN), .sram_WEN(sram_WEN), .sram_BWEN(sram_BWEN),
        .sram_A(sram_A), .sram_D(sram_D), .sram_Q(sram_Q)
    );

    always #5 clock = ~clock;

    function automatic logic [B-1:0] rnd();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // macro model: garbage on Q in cycles without a read
    always @(posedge clock) begin
        if (!sram_CEN && !sram_WEN)
            smem[sram_A] <= (smem[sram_A] & sram_BWEN) | (sram_D & ~sram_BWEN);
        sram_Q <= (!sram_CEN && sram_WEN) ? smem[sram_A] : rnd();
        if (scramble)
            for (int i = 0; i < D; i++) smem[i] <= rnd();
    end

    task automatic chk(input string tag, input logic [B-1:0] act, input logic [B-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            if (s0_resp_valid) begin
                if (q0.size() == 0) chk("s0_resp_spurious", 1, 0);
                else chk("s0_rdata", s0_resp_rdata, q0.pop_front());
            end
            if (s1_resp_valid) begin
                if (q1.size() == 0) chk("s1_resp_spurious", 1, 0);
                else chk("s1_rdata", s1_resp_rdata, q1.pop_front());
            end
        end
        if (reset) begin
            q0.delete();
            q1.delete();
        end
        if (reset || flush) begin
            for (int i = 0; i < D; i++) ref_mem[i] = '0;
        end else begin
            chk("one_grant", s0_req_ready & s1_req_ready, 0);
            chk("ready_no_valid", (s0_req_ready & ~s0_req_valid) | (s1_req_ready & ~s1_req_valid), 0);
            if (s0_req_valid && s0_req_ready) begin
                if (s0_req_write)
                    ref_mem[s0_req_addr] = (ref_mem[s0_req_addr] & ~s0_req_wmask) | (s0_req_wdata & s0_req_wmask);
                else q0.push_back(ref_mem[s0_req_addr]);
            end
            if (s1_req_valid && s1_req_ready) begin
                if (s1_req_write)
                    ref_mem[s1_req_addr] = (ref_mem[s1_req_addr] & ~s1_req_wmask) | (s1_req_wdata & s1_req_wmask);
                else q1.push_back(ref_mem[s1_req_addr]);
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic samp();
        @(negedge clock);
    endtask

    task automatic req(input int k, input logic w, input logic [AW-1:0] a,
                       input logic [B-1:0] d = '0, input logic [B-1:0] m = '1);
        if (k == 0) begin
            s0_req_valid = 1'b1; s0_req_write = w; s0_req_addr = a; s0_req_wdata = d; s0_req_wmask = m;
        end else begin
            s1_req_valid = 1'b1; s1_req_write = w; s1_req_addr = a; s1_req_wdata = d; s1_req_wmask = m;
        end
    endtask

    task automatic idle();
        s0_req_valid = 1'b0;
        s1_req_valid = 1'b0;
    endtask

    task automatic wait_init();
        for (int i = 0; i < 100 && !init_done; i++) begin
            step();
            samp();
        end
        chk("init_timeout", init_done, 1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        step();
        step();
        reset = 1'b0;
        samp();
        wait_init();
    endtask

    task automatic sweep(input string tag);
        for (int i = 0; i < D; i++) begin
            samp();
            chk({tag, "_ready"}, s0_req_ready | s1_req_ready, 0);
            chk({tag, "_A"}, sram_A, i);
            chk({tag, "_cen_wen"}, {sram_CEN, sram_WEN}, 0);
            chk({tag, "_bwen"}, sram_BWEN, 0);
            chk({tag, "_init_done"}, init_done, 0);
            step();
            if (i == D - 1) idle();
        end
        samp();
        chk({tag, "_init_done_end"}, init_done, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        req(0, 1'b0, 0);
        req(1, 1'b0, 0);
        scramble = 1'b1;
        @(posedge clock);
        #1 scramble = 1'b0;
        step();
        reset = 1'b0;
        sweep("init");
        step(); req(0, 1'b0, 5); samp(); chk("rd5_ready", s0_req_ready, 1);
        step(); idle(); samp(); chk("rd5_valid", s0_resp_valid, 1); chk("rd5_data", s0_resp_rdata, 0);

        step(); req(0, 1'b1, 3, '1, 128'hFF); samp(); chk("wr3_ready", s0_req_ready, 1);
        step(); req(0, 1'b0, 3); samp(); chk("rd3_ready", s0_req_ready, 1);
        step(); idle(); samp(); chk("rd3_valid", s0_resp_valid, 1); chk("rd3_data", s0_resp_rdata, 128'hFF);
        repeat (10) begin
            step(); samp();
            chk("hold_valid", s0_resp_valid, 0);
            chk("hold_data", s0_resp_rdata, 128'hFF);
        end

        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(); req(0, 1'b0, AW'(i)); req(1, 1'b0, AW'(i + 8)); samp();
            chk("alt_ready0", s0_req_ready, i % 2 == 0);
            chk("alt_ready1", s1_req_ready, i % 2 == 1);
            if (i > 0) begin
                chk("alt_resp0", s0_resp_valid, (i - 1) % 2 == 0);
                chk("alt_resp1", s1_resp_valid, (i - 1) % 2 == 1);
            end
        end
        step(); idle(); samp(); chk("alt_resp0_end", s0_resp_valid, 0); chk("alt_resp1_end", s1_resp_valid, 1);

        for (int i = 0; i < 3; i++) begin
            step(); idle(); req(1, 1'b0, AW'(i)); samp();
            chk("solo_ready1", s1_req_ready, 1); chk("solo_ready0", s0_req_ready, 0);
        end
        step(); req(0, 1'b0, 1); req(1, 1'b0, 2); samp();
        chk("tie_ready0", s0_req_ready, 1); chk("tie_ready1", s1_req_ready, 0);

        step(); idle(); req(0, 1'b1, 7, 128'hA5, '1); samp(); chk("wr7_ready", s0_req_ready, 1);
        step(); req(0, 1'b0, 7); samp(); chk("rd7_ready", s0_req_ready, 1);
        step(); idle(); flush = 1'b1; req(1, 1'b0, 9); samp();
        chk("flush_resp_valid", s0_resp_valid, 1);
        chk("flush_resp_data", s0_resp_rdata, 128'hA5);
        chk("flush_no_grant", s1_req_ready, 0);
        step(); flush = 1'b0;
        sweep("flush");
        step(); req(0, 1'b0, 7); samp(); chk("rd7b_ready", s0_req_ready, 1);
        step(); idle(); samp(); chk("rd7b_valid", s0_resp_valid, 1); chk("rd7b_data", s0_resp_rdata, 0);

        step(); req(0, 1'b0, 2); samp(); chk("rst_rd_ready", s0_req_ready, 1);
        step(); idle(); reset = 1'b1; samp();
        step(); reset = 1'b0; samp();
        chk("rst_resp_valid", s0_resp_valid, 0);
        chk("rst_init_done", init_done, 0);
        chk("rst_A", sram_A, 0);
        chk("rst_wen", sram_WEN, 0);
        step(); samp(); chk("rst_A1", sram_A, 1);
        wait_init();

        for (int i = 0; i < 60; i++) begin
            step(); idle();
            if ($urandom_range(0, 3) != 0) req(0, 1'($urandom), AW'($urandom_range(0, 7)), rnd(), rnd());
            if ($urandom_range(0, 3) != 0) req(1, 1'($urandom), AW'($urandom_range(0, 7)), rnd(), rnd());
            samp();
        end
        step(); idle(); samp();
        step(); samp();
        chk("drain", q0.size() + q1.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sram_bw_port_arbiter.md
Name: sram_bw_port_arbiter

Overview:
- Controller in front of one single-port, bit-write-enable SRAM macro (active-low CEN/WEN/BWEN, 1-cycle read latency).
- Shares the macro between two requesters (s0, s1) with round-robin arbitration.
- Zero-fills the array after reset or on flush.
- Captures and holds read data, because the macro output is undefined in cycles without a read.

Parameters:
- Bits, 128, data width.
- Word_Depth, 64, number of SRAM words.
- Add_Width, 6, address width (clog2 of Word_Depth).

Ports:
- clock  input  1  single clock
- reset  input  1  synchronous, active-high reset
- flush  input  1  one-cycle pulse: re-zero the whole array
- init_done  output  1  high when the array is cleared and requests are accepted
- sN_req_valid  input  1  request valid, N=0,1
- sN_req_ready  output  1  request accepted this cycle
- sN_req_write  input  1  1=write, 0=read
- sN_req_addr  input  Add_Width  word address
- sN_req_wdata  input  Bits  write data
- sN_req_wmask  input  Bits  active-high bit write mask
- sN_resp_valid  output  1  read data valid (one-cycle pulse)
- sN_resp_rdata  output  Bits  read data
- sram_CEN  output  1  macro chip enable, active low
- sram_WEN  output  1  macro write enable, active low
- sram_BWEN  output  Bits  macro bit write enable, active low
- sram_A  output  Add_Width  macro address
- sram_D  output  Bits  macro write data
- sram_Q  input  Bits  macro read data

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high on clock/reset.
- Reset values:
  - state=INIT, init counter=0, rr pointer=0 (s0 favoured), init_done=0.
  - Both resp_valid=0, both hold registers=0.
  - Readies=0.
- Idle SRAM drive: CEN=1, WEN=1, BWEN=all ones, A=0, D=0.
- SRAM outputs are combinational from state and grant; the macro samples them at the next edge.
- INIT state:
  - Every cycle: CEN=0, WEN=0, BWEN=all zeros, D=0, A=counter; counter increments.
  - On the cycle with counter==Word_Depth-1: go to RUN and set init_done=1 at that edge.
  - Total Word_Depth cycles; both readies=0 throughout.
  - flush in INIT: ignored; the sweep continues.
- RUN state, arbitration:
  - Only one port valid: grant it.
  - Both valid: grant the port the rr pointer favours; the pointer then favours the other port.
  - A grant to port k sets the pointer to favour port 1-k.
  - No valid requests: pointer unchanged.
  - sN_req_ready = grant_N. Ready may depend combinationally on valid; a requester must not make valid depend on ready.
- RUN state, granted transaction drive:
  - Write: CEN=0, WEN=0, BWEN=~wmask, A=addr, D=wdata. Bits with wmask=0 are preserved in the array. No response is generated.
  - Read: CEN=0, WEN=1, BWEN=all ones, A=addr.
- Read response:
  - Read accepted in cycle T: sN_resp_valid=1 in T+1 only, with sN_resp_rdata=sram_Q (combinational pass-through).
  - In T+1 the hold register captures sram_Q. Outside response cycles, sN_resp_rdata=hold register, stable until that port's next read response.
  - Back-to-back reads from the same port are allowed: one per cycle, responses in order.
- flush:
  - flush=1 in RUN: no grant that cycle (readies=0). Next state=INIT, counter=0, init_done=0 at that edge.
  - A read accepted in the cycle before flush still delivers its response in the flush cycle.
- Reset mid-operation (INIT or RUN): abort immediately to reset values. Any pending response is dropped (resp_valid=0 in the next cycle).
- Address: no range check; addresses ≥ Word_Depth pass through unchanged.

Test Plan:
- Reset, hold all valids high → readies=0 for 64 cycles; sram_A sweeps 0..63 with WEN=0 and BWEN=0; init_done=1 after cycle 64; a read of addr 5 then returns 0.
- s0 writes addr 3, wdata=all ones, wmask=0x00FF; then s0 reads addr 3 → in the cycle after the read is accepted, resp_valid=1 and rdata=0x…00FF (upper 120 bits 0). rdata holds that value for 10 idle cycles, including cycles where sram_Q is randomised.
- Both ports valid with reads for 4 consecutive cycles, starting right after reset → grants alternate s0, s1, s0, s1; each resp_valid pulses exactly one cycle after its grant.
- s1 valid alone for 3 cycles, then both valid → s1 granted 3×, then s0 wins the tie.
- Write addr 7 = 0xA5 (full mask), read addr 7, assert flush in the response cycle → resp_valid=1 with 0xA5 in that cycle; init_done=0 next cycle; INIT lasts 64 cycles; a later read of addr 7 returns 0.
- Assert reset during the RUN phase with a read outstanding → next cycle resp_valid=0, init_done=0, sram_A=0 with WEN=0; the sweep restarts from 0.
